// File: rtl/fft_bfly_addr_gen.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT of run-time size N.
// Emits one butterfly beat per accepted handshake, stage by stage, with optional drain gaps.
module fft_bfly_addr_gen #(
  parameter int MAX_N      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int STAGE_W    = 4,
  parameter int DRAIN      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [ADDR_WIDTH-1:0] tw_k,
  output logic [ADDR_WIDTH:0]   tw_n,
  output logic [STAGE_W-1:0]    stage,
  output logic                  stage_end,
  output logic                  last
);

  localparam int NW    = ADDR_WIDTH + 1;
  localparam int GAP_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, every beat output holds its value.

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] tw_k;
    logic [NW-1:0]         tw_n;
    logic [STAGE_W-1:0]    stage;
    logic                  stage_end;
    logic                  last;
  } beat_t;

  state_t                state;
  beat_t                 beat_q;
  beat_t                 next_beat;
  logic [STAGE_W-1:0]    stage_cnt;
  logic [ADDR_WIDTH-1:0] j_cnt;
  logic [ADDR_WIDTH-1:0] j_max;
  logic [STAGE_W-1:0]    s_max;
  logic [GAP_W-1:0]      gap_cnt;

  logic                  cfg_ok;
  logic [STAGE_W-1:0]    cfg_log2;
  logic [ADDR_WIDTH-1:0] cfg_jmax;
  logic [STAGE_W-1:0]    adv_stage;
  logic [ADDR_WIDTH-1:0] adv_j;

  // Butterfly j of a stage: p = position inside the group, g = group index.
  function automatic beat_t make_beat(input logic [STAGE_W-1:0]    stg,
                                      input logic [ADDR_WIDTH-1:0] jj,
                                      input logic [ADDR_WIDTH-1:0] jmax,
                                      input logic [STAGE_W-1:0]    smax);
    beat_t                 b;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] p;
    logic [ADDR_WIDTH-1:0] g;
    span        = ADDR_WIDTH'(1) << stg;
    p           = jj & (span - ADDR_WIDTH'(1));
    g           = jj >> stg;
    b.addr_a    = (g << (stg + STAGE_W'(1))) | p;
    b.addr_b    = b.addr_a + span;
    b.tw_k      = p;
    b.tw_n      = NW'(1) << (stg + STAGE_W'(1));
    b.stage     = stg;
    b.stage_end = (jj == jmax);
    b.last      = (jj == jmax) && (stg == smax);
    return b;
  endfunction

  always_comb begin
    cfg_log2 = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      if (n_cfg[i]) cfg_log2 = STAGE_W'(i);
    end
    cfg_ok   = (n_cfg >= NW'(2)) && (n_cfg <= NW'(MAX_N)) &&
               ((n_cfg & (n_cfg - NW'(1))) == '0);
    cfg_jmax = ADDR_WIDTH'((n_cfg >> 1) - NW'(1));
  end

  always_comb begin
    adv_stage = stage_cnt;
    adv_j     = j_cnt + ADDR_WIDTH'(1);
    if (beat_q.stage_end) begin
      adv_stage = stage_cnt + STAGE_W'(1);
      adv_j     = '0;
    end
    next_beat = make_beat(adv_stage, adv_j, j_max, s_max);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_q    <= '0;
      stage_cnt <= '0;
      j_cnt     <= '0;
      j_max     <= '0;
      s_max     <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state     <= RUN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              stage_cnt <= '0;
              j_cnt     <= '0;
              j_max     <= cfg_jmax;
              s_max     <= cfg_log2 - STAGE_W'(1);
              beat_q    <= make_beat('0, '0, cfg_jmax, cfg_log2 - STAGE_W'(1));
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (out_valid && out_ready) begin
            if (beat_q.last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              stage_cnt <= '0;
              j_cnt     <= '0;
            end else if (beat_q.stage_end && (DRAIN > 0)) begin
              // Hold off the next stage so the datapath pipeline can drain.
              state     <= GAP;
              out_valid <= 1'b0;
              gap_cnt   <= '0;
              stage_cnt <= adv_stage;
              j_cnt     <= '0;
            end else begin
              stage_cnt <= adv_stage;
              j_cnt     <= adv_j;
              beat_q    <= next_beat;
            end
          end
        end
        GAP: begin
          if (32'(gap_cnt) == DRAIN - 1) begin
            state     <= RUN;
            out_valid <= 1'b1;
            beat_q    <= make_beat(stage_cnt, '0, j_max, s_max);
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign addr_a    = beat_q.addr_a;
  assign addr_b    = beat_q.addr_b;
  assign tw_k      = beat_q.tw_k;
  assign tw_n      = beat_q.tw_n;
  assign stage     = beat_q.stage;
  assign stage_end = beat_q.stage_end;
  assign last      = beat_q.last;

endmodule

// File: doc/fft_bfly_addr_gen.md
# fft_bfly_addr_gen

Sequencer for an in-place radix-2 DIT FFT of run-time size N (2..MAX_N). It iterates every stage and every butterfly, and for each one emits the data-memory address pair plus the twiddle index/size pair (tw_k, tw_n). tw_k and tw_n connect directly to the k/n inputs of the unified twiddle ROM. It sits upstream of the twiddle ROM and the butterfly datapath, and uses a valid/ready handshake toward the datapath.

## Interface
- MAX_N, 1024, largest supported FFT size (power of two)
- ADDR_WIDTH, 10, log2(MAX_N)
- STAGE_W, 4, stage counter width, ceil(log2(ADDR_WIDTH+1))
- DRAIN, 0, idle cycles inserted between stages for datapath pipeline drain (0 = back-to-back)

Ports:
- clk  in  1  single clock; all flops rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new transform; sampled only in IDLE
- n_cfg  in  ADDR_WIDTH+1  FFT size; must be a power of two in 2..MAX_N
- busy  out  1  high while a transform is in progress (RUN/GAP)
- done  out  1  one-cycle pulse at end of transform or on rejected start
- err  out  1  one-cycle pulse with done when n_cfg is invalid
- out_valid  out  1  beat available
- out_ready  in  1  datapath accepts beat
- addr_a  out  ADDR_WIDTH  upper butterfly operand address
- addr_b  out  ADDR_WIDTH  lower butterfly operand address
- tw_k  out  ADDR_WIDTH  twiddle index for the ROM
- tw_n  out  ADDR_WIDTH+1  twiddle size for the ROM
- stage  out  STAGE_W  current stage, 0-based
- stage_end  out  1  beat is the last of its stage
- last  out  1  beat is the last of the transform

## Operation
- FSM states: IDLE, RUN, GAP.
  - IDLE + start, valid n_cfg: latch N and S = log2(N); go to RUN with stage=0, j=0.
  - IDLE + start, invalid n_cfg (not a power of two, <2, or >MAX_N): stay in IDLE; pulse done and err; no beats.
  - RUN, beat accepted (out_valid && out_ready):
    - j < N/2-1: j++.
    - Otherwise, if stage < S-1: stage++, j=0; go to GAP if DRAIN>0, else stay in RUN.
    - Otherwise (last beat): go to IDLE and pulse done.
  - GAP: count DRAIN cycles with out_valid=0, then return to RUN.
- Per beat, with span = 2^stage, p = j & (span-1), g = j >> stage:
  - addr_a = (g << (stage+1)) | p
  - addr_b = addr_a + span
  - tw_k = p
  - tw_n = 2^(stage+1)
  - Consequence: tw_k < tw_n/2 always, so the ROM midpoint and conjugate paths are never exercised by this block.
- stage_end = (j == N/2-1); last = stage_end && (stage == S-1).
- Input is bit-reversed and output is natural order; data reordering is outside this block.
- start while busy is ignored. n_cfg is sampled only at the accepted start.

## Timing
- Reset: state IDLE, all outputs 0, all counters 0. Reset takes effect immediately (asynchronous), including mid-transform; no partial-transform state survives.
- All outputs are registered. A start accepted at cycle t gives out_valid=1 with beat (stage 0, j=0) at t+1. For an invalid start, done=err=1 at t+1.
- Handshake:
  - While out_valid && !out_ready, all beat outputs hold stable.
  - out_valid never drops without an accept, except at a stage boundary or on reset.
  - With out_ready=1 continuously, one beat per cycle.
- Stage boundary: after the stage_end beat is accepted at cycle t, out_valid=0 for cycles t+1..t+DRAIN, and the first beat of the next stage appears at t+DRAIN+1.
- Completion: when the last beat is accepted at cycle t:
  - done=1 and busy=0 at t+1; out_valid=0 at t+1.
  - A new start is accepted at t+1 at the earliest.
- Minimum cycles from start to done: S*N/2 + (S-1)*DRAIN + 1.

## Test plan
- N=8, DRAIN=0, out_ready=1 → 12 consecutive beats (addr_a,addr_b,tw_k,tw_n), then done pulses at beat 12 + 1 cycle:
  - stage 0: (0,1,0,2), (2,3,0,2), (4,5,0,2), (6,7,0,2)
  - stage 1: (0,2,0,4), (1,3,1,4), (4,6,0,4), (5,7,1,4)
  - stage 2: (0,4,0,8), (1,5,1,8), (2,6,2,8), (3,7,3,8), with last on the final beat.
- N=4, out_ready driven with a random pattern → exactly 4 beats, each held stable while stalled, in order (0,1,0,2), (2,3,0,2), (0,2,0,4), (1,3,1,4); no beat dropped or duplicated.
- N=2 → single beat (0,1,0,2) with stage_end=last=1. N=1024 → 5120 beats; final beat (511,1023,511,1024), stage=9.
- n_cfg = 0, 1, 12, 2048 → done and err both pulse one cycle after start; out_valid and busy stay 0.
- DRAIN=3 instance, N=8 → exactly 3 idle cycles after each stage_end beat (two gaps total); start pulses during busy have no effect.
- rst asserted in stage 1 of an N=8 run → all outputs 0 immediately. After release, start with N=4 → first beat (0,1,0,2) next cycle.
